// File: rtl/cpu_step_ctrl_pkg.sv
// rtl/cpu_step_ctrl_pkg.sv - shared state encodings and default timing values for cpu_step_ctrl
package cpu_step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_HALT = 2'b11
  } cpu_state_t;

  localparam int DEF_DIV_DFLT = 12_500_000;
  localparam int DB_CYC_DFLT  = 50_000;

endpackage

// File: rtl/cpu_step_ctrl_btn_debounce.sv
// rtl/cpu_step_ctrl_btn_debounce.sv - 2-FF synchronizer plus stability counter for the step button
module btn_debounce #(
  parameter int DB_CYC = 50_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_rise
);

  localparam int CW = $clog2((DB_CYC > 1) ? DB_CYC : 2);
  localparam logic [CW-1:0] LAST = CW'(DB_CYC - 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  // r_cnt counts consecutive samples that disagree with the stable level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b00;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      r_rise <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
        r_rise  <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - clock-enable scheduler: run/step/halt FSM, rate divider, retired-cycle counter
module cpu_step_ctrl
  import cpu_step_ctrl_pkg::*;
#(
  parameter int DIV_W   = 24,
  parameter int DEF_DIV = DEF_DIV_DFLT,
  parameter int DB_CYC  = DB_CYC_DFLT,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt_req,
  input  logic [1:0]       div_sel,
  output logic             cpu_ce,
  output logic [1:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [DIV_W-1:0] DEF_DIV_V = DIV_W'(DEF_DIV);

  cpu_state_t       r_state;
  cpu_state_t       w_next_state;
  logic             r_ce;
  logic             w_next_ce;
  logic             r_halted;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_next;
  logic [CNT_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_shift;
  logic [DIV_W-1:0] w_period_m1;
  logic             w_tick;
  logic             w_step_rise;

  btn_debounce #(.DB_CYC(DB_CYC)) u_step_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (step_btn),
    .o_rise (w_step_rise)
  );

  // A shift that underflows to zero means a period of one cycle
  assign w_shift     = DEF_DIV_V >> {div_sel, 2'b00};
  assign w_period_m1 = (w_shift == '0) ? '0 : w_shift - DIV_W'(1);
  assign w_tick      = (r_div >= w_period_m1);

  always_comb begin
    w_next_state = r_state;
    w_next_ce    = 1'b0;
    w_div_next   = '0;
    case (r_state)
      ST_IDLE: begin
        if (run_sw) begin
          w_next_state = ST_RUN;
        end else if (w_step_rise) begin
          w_next_state = halt_req ? ST_HALT : ST_STEP;
          w_next_ce    = ~halt_req;
        end
      end
      ST_RUN: begin
        if (!run_sw) begin
          w_next_state = ST_IDLE;
        end else if (w_tick) begin
          if (halt_req) w_next_state = ST_HALT;
          else          w_next_ce    = 1'b1;
        end else begin
          w_div_next = r_div + DIV_W'(1);
        end
      end
      ST_STEP: w_next_state = ST_IDLE;
      ST_HALT: if (!run_sw) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_ce     <= 1'b0;
      r_halted <= 1'b0;
      r_div    <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_next_state;
      r_ce     <= w_next_ce;
      r_halted <= (w_next_state == ST_HALT);
      r_div    <= w_div_next;
      r_cnt    <= r_cnt + CNT_W'(r_ce);
    end
  end

  assign cpu_ce    = r_ce;
  assign state     = r_state;
  assign halted    = r_halted;
  assign cycle_cnt = r_cnt;

endmodule
